wb_unit: RTL and testbench

- Multi-cycle write-back unit for the NPC core.
- Accepts one retiring instruction per handshake and decodes its write-back source from the opcode: PC+4, ALU result, immediate, memory load or CSR read.
- For loads, waits for the memory response, then lane-selects and sign- or zero-extends the data.
- Issues exactly one register-file write per instruction, or none. Sits between execute/LSU and the register file.

---
 rtl/wb_unit.sv | 195 +++++++++++++++++++
 tb/tb_wb_unit.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_unit.sv
// Write-back unit: latches one retiring instruction, resolves its write-back value
// (ALU, immediate, PC+4, CSR or lane-extracted load data) and issues at most one RF write.
module wb_unit #(
    parameter int XLEN        = 32,
    parameter int REG_AW      = 5,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic [REG_AW-1:0] rd,
    input  logic [XLEN-1:0]   pc,
    input  logic [XLEN-1:0]   alu_result,
    input  logic [XLEN-1:0]   imm,
    input  logic [XLEN-1:0]   csr_rdata,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              mem_rready,
    output logic              rf_wen,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [XLEN-1:0]   rf_wdata,
    output logic              wb_done,
    output logic              wb_err
);

    localparam int OFF_W = $clog2(XLEN / 8);
    localparam int CNT_W = 10;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_MEM,
        WRITE,
        ERR
    } state_t;

    typedef enum logic [2:0] {
        SRC_NONE,
        SRC_ALU,
        SRC_IMM,
        SRC_PC4,
        SRC_MEM,
        SRC_CSR,
        SRC_ILL
    } src_t;

    state_t             state, state_nxt;
    src_t               dec_src, src_q;
    logic [XLEN-1:0]    dec_data;
    logic [XLEN-1:0]    data_q;
    logic [REG_AW-1:0]  rd_q;
    logic [2:0]         f3_q;
    logic [OFF_W-1:0]   off_q;
    logic [CNT_W-1:0]   cnt;
    logic               timeout;
    logic [XLEN-1:0]    lane;
    logic [XLEN-1:0]    load_data;
    logic               load_ok;
    logic               accept;

    assign accept  = (state == IDLE) && in_valid;
    assign timeout = (cnt == CNT_W'(MEM_TIMEOUT - 1));

    always_comb begin
        case (opcode)
            7'b0010111, 7'b0010011, 7'b0110011: dec_src = SRC_ALU;
            7'b0110111:                         dec_src = SRC_IMM;
            7'b1101111, 7'b1100111:             dec_src = SRC_PC4;
            7'b0000011:                         dec_src = SRC_MEM;
            7'b1110011:                         dec_src = SRC_CSR;
            7'b0100011, 7'b1100011:             dec_src = SRC_NONE;
            default:                            dec_src = SRC_ILL;
        endcase
    end

    // Non-load values are resolved at acceptance so only one data register is kept.
    always_comb begin
        dec_data = '0;
        case (dec_src)
            SRC_ALU: dec_data = alu_result;
            SRC_IMM: dec_data = imm;
            SRC_PC4: dec_data = pc + XLEN'(4);
            SRC_CSR: dec_data = csr_rdata;
            default: dec_data = '0;
        endcase
    end

    assign lane = mem_rdata >> {off_q, 3'b000};

    always_comb begin
        load_ok   = 1'b1;
        load_data = '0;
        case (f3_q)
            3'b000: load_data = XLEN'($signed(lane[7:0]));
            3'b001: load_data = XLEN'($signed(lane[15:0]));
            3'b010: load_data = XLEN'($signed(lane[31:0]));
            3'b100: load_data = XLEN'(lane[7:0]);
            3'b101: load_data = XLEN'(lane[15:0]);
            3'b011: begin
                load_ok   = (XLEN == 64);
                load_data = lane;
            end
            3'b110: begin
                load_ok   = (XLEN == 64);
                load_data = XLEN'(lane[31:0]);
            end
            default: load_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        mem_rready = 1'b0;
        rf_wen     = 1'b0;
        rf_waddr   = '0;
        rf_wdata   = '0;
        wb_done    = 1'b0;
        wb_err     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    case (dec_src)
                        SRC_MEM: state_nxt = WAIT_MEM;
                        SRC_ILL: state_nxt = ERR;
                        default: state_nxt = WRITE;
                    endcase
                end
            end
            WAIT_MEM: begin
                mem_rready = 1'b1;
                // Data arriving on the timeout cycle still wins.
                if (mem_rvalid) begin
                    state_nxt = load_ok ? WRITE : ERR;
                end else if (timeout) begin
                    state_nxt = ERR;
                end
            end
            WRITE: begin
                wb_done = 1'b1;
                if ((rd_q != '0) && (src_q != SRC_NONE)) begin
                    rf_wen   = 1'b1;
                    rf_waddr = rd_q;
                    rf_wdata = data_q;
                end
                state_nxt = IDLE;
            end
            ERR: begin
                wb_err    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q  <= SRC_NONE;
            rd_q   <= '0;
            f3_q   <= '0;
            off_q  <= '0;
            data_q <= '0;
        end else if (accept) begin
            src_q  <= dec_src;
            rd_q   <= rd;
            f3_q   <= funct3;
            off_q  <= alu_result[OFF_W-1:0];
            data_q <= dec_data;
        end else if ((state == WAIT_MEM) && mem_rvalid) begin
            data_q <= load_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if ((state == WAIT_MEM) && !mem_rvalid) begin
            cnt <= cnt + 1'b1;
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: tb/tb_wb_unit.sv
// Directed bench for wb_unit (XLEN=32, MEM_TIMEOUT=4): one task per scenario with inline checks.
module tb_wb_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] alu_result;
    logic [31:0] imm;
    logic [31:0] csr_rdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_rready;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        wb_done;
    logic        wb_err;

    int errors = 0;
    int checks = 0;

    wb_unit #(
        .XLEN        (32),
        .REG_AW      (5),
        .MEM_TIMEOUT (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .opcode     (opcode),
        .funct3     (funct3),
        .rd         (rd),
        .pc         (pc),
        .alu_result (alu_result),
        .imm        (imm),
        .csr_rdata  (csr_rdata),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .mem_rready (mem_rready),
        .rf_wen     (rf_wen),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .wb_done    (wb_done),
        .wb_err     (wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction in IDLE; returns one cycle after the accepting edge.
    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] r,
                         input logic [31:0] p, input logic [31:0] a, input logic [31:0] i,
                         input logic [31:0] c);
        in_valid   = 1'b1;
        opcode     = op;
        funct3     = f3;
        rd         = r;
        pc         = p;
        alu_result = a;
        imm        = i;
        csr_rdata  = c;
        step();
        in_valid   = 1'b0;
    endtask

    // Load with `waits` idle WAIT_MEM cycles before the data beat; returns in the WRITE/ERR cycle.
    task automatic do_load(input logic [2:0] f3, input logic [4:0] r, input logic [31:0] addr,
                           input int waits, input logic [31:0] data);
        issue(7'b0000011, f3, r, 32'h0, addr, 32'h0, 32'h0);
        repeat (waits) step();
        mem_rvalid = 1'b1;
        mem_rdata  = data;
        step();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) step();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL reset_rf_wen: got %b want 0", rf_wen); end
        checks++; if (mem_rready !== 1'b0) begin errors++; $display("FAIL reset_mem_rready: got %b want 0", mem_rready); end
        checks++; if ({wb_done, wb_err} !== 2'b00) begin errors++; $display("FAIL reset_pulses: got %b want 00", {wb_done, wb_err}); end
        checks++; if ({rf_waddr, rf_wdata} !== 37'h0) begin errors++; $display("FAIL reset_addr_data: got %h want 0", {rf_waddr, rf_wdata}); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_alu();
        issue(7'b0010011, 3'b000, 5'd5, 32'h100, 32'h0000_1234, 32'h0, 32'h0);
        checks++; if (rf_wen !== 1'b1) begin errors++; $display("FAIL addi_wen: got %b want 1", rf_wen); end
        checks++; if (rf_waddr !== 5'd5) begin errors++; $display("FAIL addi_waddr: got %0d want 5", rf_waddr); end
        checks++; if (rf_wdata !== 32'h0000_1234) begin errors++; $display("FAIL addi_wdata: got %h want 00001234", rf_wdata); end
        checks++; if (wb_done !== 1'b1) begin errors++; $display("FAIL addi_done: got %b want 1", wb_done); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL addi_busy: got %b want 0", in_ready); end
        step();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL addi_ready_after: got %b want 1", in_ready); end
        checks++; if ({rf_wen, wb_done, rf_waddr, rf_wdata} !== 39'h0) begin errors++; $display("FAIL addi_idle_outs: got %h want 0", {rf_wen, wb_done, rf_waddr, rf_wdata}); end
        issue(7'b0110011, 3'b000, 5'd31, 32'h0, 32'hA5A5_0F0F, 32'h1111_1111, 32'h2222_2222);
        checks++; if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd31, 32'hA5A5_0F0F}) begin errors++; $display("FAIL op_write: got %h want %h", {rf_wen, rf_waddr, rf_wdata}, {1'b1, 5'd31, 32'hA5A5_0F0F}); end
        step();
    endtask

    task automatic test_sources();
        issue(7'b1101111, 3'b000, 5'd1, 32'hFFFF_FFFC, 32'h5555_5555, 32'h8, 32'h0);
        checks++; if ({rf_wen, rf_waddr} !== {1'b1, 5'd1}) begin errors++; $display("FAIL jal_wen_addr: got %h want 21", {rf_wen, rf_waddr}); end
        checks++; if (rf_wdata !== 32'h0000_0000) begin errors++; $display("FAIL jal_wrap: got %h want 00000000", rf_wdata); end
        step();
        issue(7'b1100111, 3'b000, 5'd2, 32'h0000_1000, 32'h0, 32'h0, 32'h0);
        checks++; if (rf_wdata !== 32'h0000_1004) begin errors++; $display("FAIL jalr_pc4: got %h want 00001004", rf_wdata); end
        step();
        issue(7'b0110111, 3'b000, 5'd0, 32'h0, 32'h0, 32'h1234_5000, 32'h0);
        checks++; if ({rf_wen, wb_done} !== 2'b01) begin errors++; $display("FAIL lui_rd0: got wen/done %b want 01", {rf_wen, wb_done}); end
        checks++; if (rf_wdata !== 32'h0) begin errors++; $display("FAIL lui_rd0_data: got %h want 0", rf_wdata); end
        step();
        issue(7'b0110111, 3'b000, 5'd6, 32'h0, 32'h9, 32'hABCD_E000, 32'h0);
        checks++; if (rf_wdata !== 32'hABCD_E000) begin errors++; $display("FAIL lui_imm: got %h want abcde000", rf_wdata); end
        step();
        issue(7'b1110011, 3'b001, 5'd3, 32'h0, 32'h7, 32'h0, 32'hDEAD_BEEF);
        checks++; if (rf_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL csr_data: got %h want deadbeef", rf_wdata); end
        step();
        issue(7'b0010111, 3'b000, 5'd4, 32'h40, 32'h0000_2040, 32'h2000, 32'h0);
        checks++; if (rf_wdata !== 32'h0000_2040) begin errors++; $display("FAIL auipc_data: got %h want 00002040", rf_wdata); end
        step();
    endtask

    task automatic test_loads();
        issue(7'b0000011, 3'b000, 5'd7, 32'h0, 32'h0000_1003, 32'h0, 32'h0);
        checks++; if ({mem_rready, in_ready} !== 2'b10) begin errors++; $display("FAIL wait_handshake: got rready/ready %b want 10", {mem_rready, in_ready}); end
        step();
        step();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h80AA_BBCC;
        step();
        mem_rvalid = 1'b0;
        checks++; if ({rf_wen, rf_waddr, wb_done} !== {1'b1, 5'd7, 1'b1}) begin errors++; $display("FAIL lb_ctl: got %b want 1001111", {rf_wen, rf_waddr, wb_done}); end
        checks++; if (rf_wdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_off3: got %h want ffffff80", rf_wdata); end
        step();
        do_load(3'b100, 5'd8, 32'h0000_1003, 2, 32'h80AA_BBCC);
        checks++; if (rf_wdata !== 32'h0000_0080) begin errors++; $display("FAIL lbu_off3: got %h want 00000080", rf_wdata); end
        step();
        do_load(3'b101, 5'd9, 32'h0000_2002, 0, 32'h80AA_BBCC);
        checks++; if (rf_wdata !== 32'h0000_80AA) begin errors++; $display("FAIL lhu_off2: got %h want 000080aa", rf_wdata); end
        step();
        do_load(3'b001, 5'd10, 32'h0000_2002, 1, 32'h80AA_BBCC);
        checks++; if (rf_wdata !== 32'hFFFF_80AA) begin errors++; $display("FAIL lh_off2: got %h want ffff80aa", rf_wdata); end
        step();
        do_load(3'b000, 5'd11, 32'h0000_2000, 0, 32'h80AA_BBCC);
        checks++; if (rf_wdata !== 32'hFFFF_FFCC) begin errors++; $display("FAIL lb_off0: got %h want ffffffcc", rf_wdata); end
        step();
        do_load(3'b100, 5'd11, 32'h0000_2001, 0, 32'h80AA_3BCC);
        checks++; if (rf_wdata !== 32'h0000_003B) begin errors++; $display("FAIL lbu_off1: got %h want 0000003b", rf_wdata); end
        step();
        do_load(3'b010, 5'd12, 32'h0000_2000, 0, 32'h80AA_BBCC);
        checks++; if (rf_wdata !== 32'h80AA_BBCC) begin errors++; $display("FAIL lw_word: got %h want 80aabbcc", rf_wdata); end
        step();
    endtask

    task automatic test_timeout();
        issue(7'b0000011, 3'b010, 5'd13, 32'h0, 32'h0, 32'h0, 32'h0);
        repeat (3) step();
        checks++; if ({mem_rready, wb_err} !== 2'b10) begin errors++; $display("FAIL timeout_early: got rready/err %b want 10", {mem_rready, wb_err}); end
        step();
        checks++; if ({wb_err, rf_wen, wb_done} !== 3'b100) begin errors++; $display("FAIL timeout_err: got err/wen/done %b want 100", {wb_err, rf_wen, wb_done}); end
        step();
        checks++; if ({wb_err, in_ready} !== 2'b01) begin errors++; $display("FAIL timeout_after: got err/ready %b want 01", {wb_err, in_ready}); end
        do_load(3'b010, 5'd14, 32'h0, 3, 32'h1234_5678);
        checks++; if ({wb_err, rf_wen, rf_wdata} !== {1'b0, 1'b1, 32'h1234_5678}) begin errors++; $display("FAIL timeout_edge_data: got %h want %h", {wb_err, rf_wen, rf_wdata}, {2'b01, 32'h1234_5678}); end
        step();
    endtask

    task automatic test_errors();
        issue(7'h7F, 3'b000, 5'd15, 32'h0, 32'h1, 32'h2, 32'h3);
        checks++; if ({wb_err, rf_wen, wb_done} !== 3'b100) begin errors++; $display("FAIL illegal_op: got err/wen/done %b want 100", {wb_err, rf_wen, wb_done}); end
        step();
        checks++; if ({wb_err, in_ready} !== 2'b01) begin errors++; $display("FAIL illegal_after: got err/ready %b want 01", {wb_err, in_ready}); end
        issue(7'b0100011, 3'b010, 5'd4, 32'h0, 32'h55, 32'h0, 32'h0);
        checks++; if ({wb_done, rf_wen, wb_err, rf_wdata} !== {3'b100, 32'h0}) begin errors++; $display("FAIL store_none: got %h want %h", {wb_done, rf_wen, wb_err, rf_wdata}, {3'b100, 32'h0}); end
        step();
        issue(7'b1100011, 3'b000, 5'd9, 32'h0, 32'h1, 32'h0, 32'h0);
        checks++; if ({wb_done, rf_wen} !== 2'b10) begin errors++; $display("FAIL branch_none: got done/wen %b want 10", {wb_done, rf_wen}); end
        step();
        issue(7'b0000011, 3'b111, 5'd16, 32'h0, 32'h0, 32'h0, 32'h0);
        checks++; if (wb_err !== 1'b0) begin errors++; $display("FAIL f3_111_early: got %b want 0", wb_err); end
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFE_F00D;
        step();
        mem_rvalid = 1'b0;
        checks++; if ({wb_err, rf_wen, wb_done} !== 3'b100) begin errors++; $display("FAIL f3_111_err: got err/wen/done %b want 100", {wb_err, rf_wen, wb_done}); end
        step();
        do_load(3'b011, 5'd17, 32'h0, 0, 32'h1111_2222);
        checks++; if ({wb_err, rf_wen} !== 2'b10) begin errors++; $display("FAIL ld_on_rv32: got err/wen %b want 10", {wb_err, rf_wen}); end
        step();
    endtask

    task automatic test_reset_mid_load();
        issue(7'b0000011, 3'b010, 5'd18, 32'h0, 32'h0, 32'h0, 32'h0);
        step();
        rst_n = 1'b0;
        #1;
        checks++; if ({mem_rready, rf_wen, wb_done, wb_err} !== 4'b0000) begin errors++; $display("FAIL async_reset_outs: got %b want 0000", {mem_rready, rf_wen, wb_done, wb_err}); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL async_reset_ready: got %b want 1", in_ready); end
        step();
        rst_n      = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h7777_7777;
        step();
        checks++; if ({rf_wen, wb_done, wb_err, mem_rready} !== 4'b0000) begin errors++; $display("FAIL late_rvalid: got %b want 0000", {rf_wen, wb_done, wb_err, mem_rready}); end
        step();
        checks++; if ({in_ready, rf_wen, wb_err} !== 3'b100) begin errors++; $display("FAIL late_rvalid_idle: got %b want 100", {in_ready, rf_wen, wb_err}); end
        mem_rvalid = 1'b0;
        issue(7'b0010011, 3'b000, 5'd19, 32'h0, 32'h0000_0BAD, 32'h0, 32'h0);
        checks++; if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd19, 32'h0000_0BAD}) begin errors++; $display("FAIL post_reset_op: got %h want %h", {rf_wen, rf_waddr, rf_wdata}, {1'b1, 5'd19, 32'h0000_0BAD}); end
        step();
    endtask

    task automatic test_back_to_back();
        in_valid   = 1'b1;
        opcode     = 7'b0010011;
        rd         = 5'd20;
        alu_result = 32'h0000_00AA;
        step();
        checks++; if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd20, 32'h0000_00AA}) begin errors++; $display("FAIL b2b_first: got %h want %h", {rf_wen, rf_waddr, rf_wdata}, {1'b1, 5'd20, 32'h0000_00AA}); end
        rd         = 5'd21;
        alu_result = 32'h0000_00BB;
        step();
        checks++; if ({in_ready, rf_wen, wb_done} !== 3'b100) begin errors++; $display("FAIL b2b_gap: got ready/wen/done %b want 100", {in_ready, rf_wen, wb_done}); end
        step();
        in_valid = 1'b0;
        checks++; if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd21, 32'h0000_00BB}) begin errors++; $display("FAIL b2b_second: got %h want %h", {rf_wen, rf_waddr, rf_wdata}, {1'b1, 5'd21, 32'h0000_00BB}); end
        step();
        checks++; if ({in_ready, wb_done} !== 2'b10) begin errors++; $display("FAIL b2b_end: got ready/done %b want 10", {in_ready, wb_done}); end
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        opcode     = 7'h0;
        funct3     = 3'h0;
        rd         = 5'h0;
        pc         = 32'h0;
        alu_result = 32'h0;
        imm        = 32'h0;
        csr_rdata  = 32'h0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        test_reset();
        test_alu();
        test_sources();
        test_loads();
        test_timeout();
        test_errors();
        test_reset_mid_load();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
